// File: rtl/code_decompressor_if.sv
// rtl/code_decompressor_if.sv - compressed-input, dictionary and expanded-output bundle
interface code_decompressor_if #(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8,
  parameter int IN_WIDTH  = 32
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 stream_flush;
  logic                 dict_busy;
  logic [KEY_WIDTH-1:0] dict_key_out;
  logic [VAL_WIDTH-1:0] dict_val_in;
  logic [VAL_WIDTH-1:0] out_data;
  logic                 out_compressed;
  logic                 out_valid;
  logic                 out_ready;

  modport slave (
    input  in_data, in_valid, stream_flush, dict_busy, dict_val_in, out_ready,
    output in_ready, dict_key_out, out_data, out_compressed, out_valid
  );

  modport master (
    output in_data, in_valid, stream_flush, dict_busy, dict_val_in, out_ready,
    input  in_ready, dict_key_out, out_data, out_compressed, out_valid
  );
endinterface

// File: rtl/code_decompressor.sv
// rtl/code_decompressor.sv - tagged bit-packed stream to fixed-width values via dictionary
module code_decompressor #(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8,
  parameter int IN_WIDTH  = 32
) (
  input  logic               clk,
  input  logic               resetn,
  code_decompressor_if.slave bus
);
  localparam int BUF_W    = 2 * IN_WIDTH;
  localparam int CNT_W    = $clog2(BUF_W + 1);
  localparam int KEY_ITEM = 1 + KEY_WIDTH;
  localparam int LIT_ITEM = 1 + VAL_WIDTH;

  logic [BUF_W-1:0]     bits_q, bits_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VAL_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_comp_q, out_comp_d;
  logic                 out_valid_q, out_valid_d;

  logic                 tag;
  logic [CNT_W-1:0]     item_w;
  logic [CNT_W-1:0]     cons_w;
  logic [CNT_W-1:0]     base;
  logic                 item_rdy;
  logic                 consume;
  logic                 accept;
  logic [BUF_W-1:0]     appended;

  assign tag               = bits_q[0];
  assign item_w            = tag ? CNT_W'(KEY_ITEM) : CNT_W'(LIT_ITEM);
  assign item_rdy          = (cnt_q >= item_w) && !bus.dict_busy && !bus.stream_flush;
  assign consume           = item_rdy && (!out_valid_q || bus.out_ready);
  assign bus.in_ready      = (cnt_q <= CNT_W'(IN_WIDTH)) && !bus.stream_flush;
  assign accept            = bus.in_valid && bus.in_ready;
  assign cons_w            = consume ? item_w : '0;
  // New word lands just above whatever survives this cycle's consume.
  assign base              = cnt_q - cons_w;
  assign appended          = {{IN_WIDTH{1'b0}}, bus.in_data} << base;

  assign bus.dict_key_out   = bits_q[KEY_WIDTH:1];
  assign bus.out_data       = out_data_q;
  assign bus.out_compressed = out_comp_q;
  assign bus.out_valid      = out_valid_q;

  always_comb begin
    bits_d      = bits_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_comp_d  = out_comp_q;
    out_valid_d = out_valid_q;

    if (bus.stream_flush) begin
      bits_d = '0;
      cnt_d  = '0;
    end else begin
      bits_d = (bits_q >> cons_w) | (accept ? appended : '0);
      cnt_d  = cnt_q - cons_w + (accept ? CNT_W'(IN_WIDTH) : '0);
    end

    if (consume) begin
      out_data_d  = tag ? bus.dict_val_in : bits_q[VAL_WIDTH:1];
      out_comp_d  = tag;
      out_valid_d = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bits_q      <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_comp_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      bits_q      <= bits_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_comp_q  <= out_comp_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
